// File: rtl/inst_encoder_loader_pkg.sv
// Shared definitions for the 16-bit instruction format: opcodes, classes,
// field bit positions and the loader FSM states.
package inst_encoder_loader_pkg;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpShl  = 4'h1;
    localparam logic [3:0] OpShr  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpAddi = 4'h5;
    localparam logic [3:0] OpLd   = 4'h6;
    localparam logic [3:0] OpSt   = 4'h7;
    localparam logic [3:0] OpBeq  = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;

    typedef enum logic [2:0] {
        ClsR,
        ClsShift,
        ClsImm,
        ClsJump,
        ClsRsvd
    } inst_cls_e;

    // Bit positions are shared with the control unit decoder.
    localparam int unsigned OpLsb     = 0;
    localparam int unsigned OpMsb     = 3;
    localparam int unsigned DstLsb    = 4;
    localparam int unsigned DstMsb    = 6;
    localparam int unsigned Src1Lsb   = 7;
    localparam int unsigned Src1Msb   = 9;
    localparam int unsigned Src2Lsb   = 10;
    localparam int unsigned Src2Msb   = 12;
    localparam int unsigned ShamtLsb  = 13;
    localparam int unsigned ShamtMsb  = 15;
    localparam int unsigned IconstLsb = 10;
    localparam int unsigned IconstMsb = 15;
    localparam int unsigned JconstLsb = 4;
    localparam int unsigned JconstMsb = 12;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone
    } state_e;

    function automatic inst_cls_e op_class(input logic [3:0] op);
        inst_cls_e cls;
        case (op)
            OpAdd, OpSub, OpAnd:        cls = ClsR;
            OpShl, OpShr:               cls = ClsShift;
            OpAddi, OpLd, OpSt, OpBeq:  cls = ClsImm;
            OpJmp:                      cls = ClsJump;
            default:                    cls = ClsRsvd;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/inst_encoder_loader_encode.sv
// Combinational field packer: builds the 16-bit word for the opcode's class
// and flags reserved opcodes. Fields outside the class stay zero.
module inst_encode
    import inst_encoder_loader_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic [2:0]  dst_i,
    input  logic [2:0]  src1_i,
    input  logic [2:0]  src2_i,
    input  logic [2:0]  shamt_i,
    input  logic [5:0]  iconst_i,
    input  logic [8:0]  jconst_i,
    output logic [15:0] word_o,
    output logic        legal_o
);

    inst_cls_e cls;

    always_comb begin
        word_o  = '0;
        cls     = op_class(opcode_i);
        legal_o = (cls != ClsRsvd);
        word_o[OpMsb:OpLsb] = opcode_i;
        case (cls)
            ClsR: begin
                word_o[DstMsb:DstLsb]   = dst_i;
                word_o[Src1Msb:Src1Lsb] = src1_i;
                word_o[Src2Msb:Src2Lsb] = src2_i;
            end
            ClsShift: begin
                word_o[DstMsb:DstLsb]     = dst_i;
                word_o[Src1Msb:Src1Lsb]   = src1_i;
                word_o[ShamtMsb:ShamtLsb] = shamt_i;
            end
            ClsImm: begin
                word_o[DstMsb:DstLsb]       = dst_i;
                word_o[Src1Msb:Src1Lsb]     = src1_i;
                word_o[IconstMsb:IconstLsb] = iconst_i;
            end
            ClsJump: begin
                word_o[JconstMsb:JconstLsb] = jconst_i;
            end
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: accepts field bundles, encodes them and writes the words
// sequentially into instruction memory from address 0.
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_dst,
    input  logic [2:0]        in_src1,
    input  logic [2:0]        in_src2,
    input  logic [2:0]        in_shamt,
    input  logic [5:0]        in_iconst,
    input  logic [8:0]        in_jconst,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [ADDR_W-1:0] PtrMax = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [15:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [15:0]       enc_word;
    logic              enc_legal;

    inst_encode u_encode (
        .opcode_i (in_opcode),
        .dst_i    (in_dst),
        .src1_i   (in_src1),
        .src2_i   (in_src2),
        .shamt_i  (in_shamt),
        .iconst_i (in_iconst),
        .jconst_i (in_jconst),
        .word_o   (enc_word),
        .legal_o  (enc_legal)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        count_d = count_q;
        word_d  = word_q;
        last_d  = last_q;
        full_d  = full_q;
        err_d   = err_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    if (enc_legal) begin
                        word_d  = enc_word;
                        last_d  = in_last;
                        addr_d  = ptr_q;
                        state_d = StWrite;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                count_d = count_q + (ADDR_W + 1)'(1);
                // Top address just written: stop without wrapping the pointer.
                if (ptr_q == PtrMax) begin
                    full_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = last_q ? StDone : StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = (state_q == StLoad);
    assign mem_we      = (state_q == StWrite);
    assign done        = (state_q == StDone);
    assign mem_addr    = addr_q;
    assign mem_wdata   = word_q;
    assign count       = count_q;
    assign full        = full_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench: one loader at ADDR_W=8 and one at ADDR_W=2 for the full boundary.
module tb_inst_encoder_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_a, start_b, valid_a, valid_b;
    logic [3:0] op;
    logic [2:0] dst, s1, s2, sh;
    logic [5:0] ic;
    logic [8:0] jc;
    logic       last;

    logic        ready_a, we_a, done_a, full_a, err_a;
    logic [7:0]  addr_a;
    logic [15:0] wdata_a;
    logic [8:0]  count_a;

    logic        ready_b, we_b, done_b, full_b, err_b;
    logic [1:0]  addr_b;
    logic [15:0] wdata_b;
    logic [2:0]  count_b;

    int total = 0;
    int bad   = 0;
    logic [23:0] qa[$];
    logic [23:0] qb[$];

    inst_encoder_loader #(.ADDR_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
        .in_opcode(op), .in_dst(dst), .in_src1(s1), .in_src2(s2), .in_shamt(sh),
        .in_iconst(ic), .in_jconst(jc), .in_last(last), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .count(count_a), .done(done_a), .full(full_a),
        .err_illegal(err_a)
    );

    inst_encoder_loader #(.ADDR_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_opcode(op), .in_dst(dst), .in_src1(s1), .in_src2(s2), .in_shamt(sh),
        .in_iconst(ic), .in_jconst(jc), .in_last(last), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .count(count_b), .done(done_b), .full(full_b),
        .err_illegal(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every write strobe is matched against the next expected {addr, data}.
    always @(negedge clk) begin
        if (we_a) begin
            logic [23:0] e;
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL write_a: unexpected write addr=0x%0h data=0x%0h", addr_a, wdata_a);
            end else begin
                e = qa.pop_front();
                if ({addr_a, wdata_a} !== e) begin
                    bad++;
                    $display("FAIL write_a: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                             addr_a, wdata_a, e[23:16], e[15:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (we_b) begin
            logic [23:0] e;
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL write_b: unexpected write addr=0x%0h data=0x%0h", addr_b, wdata_b);
            end else begin
                e = qb.pop_front();
                if ({6'b0, addr_b, wdata_b} !== e) begin
                    bad++;
                    $display("FAIL write_b: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                             addr_b, wdata_b, e[23:16], e[15:0]);
                end
            end
        end
    end

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Drive one bundle and hold it until accepted; push the expected write if legal.
    task automatic send(input int sel, input logic [3:0] o, input logic [2:0] d,
                        input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] s,
                        input logic [5:0] i, input logic [8:0] j, input logic l,
                        input logic push, input logic [7:0] eaddr, input logic [15:0] eword);
        int n = 0;
        @(negedge clk);
        op = o; dst = d; s1 = a1; s2 = a2; sh = s; ic = i; jc = j; last = l;
        if (push) begin
            if (sel == 0) qa.push_back({eaddr, eword}); else qb.push_back({eaddr, eword});
        end
        if (sel == 0) valid_a = 1'b1; else valid_b = 1'b1;
        while (((sel == 0) ? ready_a : ready_b) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            bad++;
            total++;
            $display("FAIL handshake_timeout: got ready=0 expected ready=1 (sel %0d)", sel);
        end else begin
            @(posedge clk);
        end
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int n = 0;
        while (((sel == 0) ? done_a : done_b) !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", {31'b0, (sel == 0) ? done_a : done_b}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        op = '0; dst = '0; s1 = '0; s2 = '0; sh = '0; ic = '0; jc = '0; last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready_a}, 0);
        chk("rst_we", {31'b0, we_a}, 0);
        chk("rst_done", {31'b0, done_a}, 0);
        chk("rst_full", {31'b0, full_a}, 0);
        chk("rst_err", {31'b0, err_a}, 0);
        chk("rst_count", {23'b0, count_a}, 0);
        chk("rst_addr", {24'b0, addr_a}, 0);
        chk("rst_wdata", {16'b0, wdata_a}, 0);
        reset = 1'b0;

        // Three words with last on the third; start is ignored while loading.
        pulse_start(0);
        @(negedge clk);
        chk("load_ready", {31'b0, ready_a}, 1);
        send(0, 4'h0, 3'd3, 3'd5, 3'd6, 3'd7, 6'h00, 9'h000, 1'b0, 1'b1, 8'd0, 16'h1AB0);
        pulse_start(0);
        @(negedge clk);
        chk("start_ignored_count", {23'b0, count_a}, 1);
        send(0, 4'h1, 3'd2, 3'd1, 3'd7, 3'd4, 6'h00, 9'h000, 1'b0, 1'b1, 8'd1, 16'h80A1);
        send(0, 4'h7, 3'd1, 3'd2, 3'd0, 3'd0, 6'h2A, 9'h000, 1'b1, 1'b1, 8'd2, 16'hA917);
        wait_done(0);
        chk("last_full", {31'b0, full_a}, 0);
        chk("last_count", {23'b0, count_a}, 3);
        chk("last_ready", {31'b0, ready_a}, 0);
        pulse_start(0);
        @(negedge clk);
        chk("restart_done", {31'b0, done_a}, 0);
        chk("restart_count", {23'b0, count_a}, 0);

        // Reserved opcode between two legal words.
        send(0, 4'h9, 3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 9'h1FF, 1'b0, 1'b1, 8'd0, 16'h1FF9);
        send(0, 4'hC, 3'd7, 3'd7, 3'd7, 3'd7, 6'h3F, 9'h1FF, 1'b0, 1'b0, 8'd0, 16'h0000);
        @(negedge clk);
        chk("rsvd_err", {31'b0, err_a}, 1);
        chk("rsvd_count", {23'b0, count_a}, 1);
        chk("rsvd_we", {31'b0, we_a}, 0);
        send(0, 4'h0, 3'd3, 3'd5, 3'd6, 3'd7, 6'h00, 9'h000, 1'b1, 1'b1, 8'd1, 16'h1AB0);
        wait_done(0);
        chk("rsvd_count_final", {23'b0, count_a}, 2);
        chk("rsvd_err_sticky", {31'b0, err_a}, 1);

        // Reset asserted while the WRITE cycle is on the bus.
        pulse_start(0);
        send(0, 4'h1, 3'd2, 3'd1, 3'd7, 3'd4, 6'h00, 9'h000, 1'b0, 1'b1, 8'd0, 16'h80A1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_we", {31'b0, we_a}, 0);
        chk("rstw_count", {23'b0, count_a}, 0);
        chk("rstw_addr", {24'b0, addr_a}, 0);
        chk("rstw_wdata", {16'b0, wdata_a}, 0);
        chk("rstw_err", {31'b0, err_a}, 0);
        chk("rstw_ready", {31'b0, ready_a}, 0);
        reset = 1'b0;

        // ADDR_W=2: four words fill memory, the fifth is refused.
        pulse_start(1);
        send(1, 4'h0, 3'd3, 3'd5, 3'd6, 3'd7, 6'h00, 9'h000, 1'b0, 1'b1, 8'd0, 16'h1AB0);
        send(1, 4'h1, 3'd2, 3'd1, 3'd7, 3'd4, 6'h00, 9'h000, 1'b0, 1'b1, 8'd1, 16'h80A1);
        send(1, 4'h7, 3'd1, 3'd2, 3'd0, 3'd0, 6'h2A, 9'h000, 1'b0, 1'b1, 8'd2, 16'hA917);
        send(1, 4'h9, 3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 9'h1FF, 1'b0, 1'b1, 8'd3, 16'h1FF9);
        wait_done(1);
        chk("full_flag", {31'b0, full_b}, 1);
        chk("full_count", {29'b0, count_b}, 4);
        @(negedge clk);
        op = 4'h0; last = 1'b0;
        valid_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_ready", {31'b0, ready_b}, 0);
        chk("full_addr_hold", {30'b0, addr_b}, 3);
        valid_b = 1'b0;

        // Last flag on the top-address word still reports full.
        pulse_start(1);
        @(negedge clk);
        chk("full_restart_full", {31'b0, full_b}, 0);
        send(1, 4'h0, 3'd3, 3'd5, 3'd6, 3'd7, 6'h00, 9'h000, 1'b0, 1'b1, 8'd0, 16'h1AB0);
        send(1, 4'h0, 3'd3, 3'd5, 3'd6, 3'd7, 6'h00, 9'h000, 1'b0, 1'b1, 8'd1, 16'h1AB0);
        send(1, 4'h0, 3'd3, 3'd5, 3'd6, 3'd7, 6'h00, 9'h000, 1'b0, 1'b1, 8'd2, 16'h1AB0);
        send(1, 4'h9, 3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 9'h1FF, 1'b1, 1'b1, 8'd3, 16'h1FF9);
        wait_done(1);
        chk("full_last_flag", {31'b0, full_b}, 1);

        repeat (3) @(negedge clk);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
